// File: rtl/chain_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : chain_decoder
//  Purpose  : Rebuilds an object border from a Freeman chain code. Each visited
//             pixel is plotted into a 64x64 binary image RAM by read-modify-
//             write of a 64-bit row. Tracks perimeter, bounding box, closure
//             and out-of-image / perimeter-overflow errors.
//  Ports    : Clk, reset (async, active-low)
//             start, start_x, start_y        - chain start request + point
//             code_valid/code_ready/code/code_last - direction code stream
//             mem_addr/mem_rd_en/mem_rdata/mem_we/mem_wdata - row RAM port
//             Perimeter, min_x/max_x/min_y/max_y - chain statistics
//             Closed, Busy, Done, Error      - status
//  Revision : 1.0 - initial release
// ============================================================================
module chain_decoder #(
   parameter int IMG_W   = 64,
   parameter int PERIM_W = 8
) (
   input  logic               Clk,
   input  logic               reset,
   input  logic               start,
   input  logic [5:0]         start_x,
   input  logic [5:0]         start_y,
   input  logic               code_valid,
   output logic               code_ready,
   input  logic [2:0]         code,
   input  logic               code_last,
   output logic [5:0]         mem_addr,
   output logic               mem_rd_en,
   input  logic [IMG_W-1:0]   mem_rdata,
   output logic               mem_we,
   output logic [IMG_W-1:0]   mem_wdata,
   output logic [PERIM_W-1:0] Perimeter,
   output logic [5:0]         min_x,
   output logic [5:0]         max_x,
   output logic [5:0]         min_y,
   output logic [5:0]         max_y,
   output logic               Closed,
   output logic               Busy,
   output logic               Done,
   output logic               Error
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_LATCH = 3'd2,
      S_WR    = 3'd3,
      S_CODE  = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [5:0]         cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic [5:0]         st_x_q, st_x_d, st_y_q, st_y_d;
   logic [PERIM_W-1:0] perim_q, perim_d;
   logic [5:0]         minx_q, minx_d, maxx_q, maxx_d;
   logic [5:0]         miny_q, miny_d, maxy_q, maxy_d;
   logic               last_q, last_d;
   logic [IMG_W-1:0]   row_q, row_d;

   // Step arithmetic in 7-bit two's complement: bit 6 set after the add means
   // the step left the image (either -1 or 64).
   logic signed [6:0] dx, dy;
   logic [6:0]        nx, ny;
   logic              off_img;
   logic [5:0]        col;
   logic [IMG_W-1:0]  pix_mask;

   always_comb begin
      dx = 7'sd0;
      dy = 7'sd0;
      case (code)
         3'd0: begin dx =  7'sd1; dy =  7'sd0; end
         3'd1: begin dx =  7'sd1; dy = -7'sd1; end
         3'd2: begin dx =  7'sd0; dy = -7'sd1; end
         3'd3: begin dx = -7'sd1; dy = -7'sd1; end
         3'd4: begin dx = -7'sd1; dy =  7'sd0; end
         3'd5: begin dx = -7'sd1; dy =  7'sd1; end
         3'd6: begin dx =  7'sd0; dy =  7'sd1; end
         default: begin dx = 7'sd1; dy = 7'sd1; end
      endcase
      nx      = {1'b0, cur_x_q} + dx;
      ny      = {1'b0, cur_y_q} + dy;
      off_img = nx[6] | ny[6];
   end

   // Column c lives at bit [IMG_W-1-c] of the row word.
   always_comb begin
      col      = 6'(IMG_W - 1) - cur_x_q;
      pix_mask = '0;
      pix_mask[col] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
      st_x_d  = st_x_q;
      st_y_d  = st_y_q;
      perim_d = perim_q;
      minx_d  = minx_q;
      maxx_d  = maxx_q;
      miny_d  = miny_q;
      maxy_d  = maxy_q;
      last_d  = last_q;
      row_d   = row_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               cur_x_d = start_x;
               cur_y_d = start_y;
               st_x_d  = start_x;
               st_y_d  = start_y;
               perim_d = '0;
               minx_d  = start_x;
               maxx_d  = start_x;
               miny_d  = start_y;
               maxy_d  = start_y;
               last_d  = 1'b0;
               state_d = S_RD;
            end
         end
         S_RD:    state_d = S_LATCH;
         S_LATCH: begin
            row_d   = mem_rdata;
            state_d = S_WR;
         end
         S_WR: begin
            if (cur_x_q < minx_q) minx_d = cur_x_q;
            if (cur_x_q > maxx_q) maxx_d = cur_x_q;
            if (cur_y_q < miny_q) miny_d = cur_y_q;
            if (cur_y_q > maxy_q) maxy_d = cur_y_q;
            state_d = last_q ? S_DONE : S_CODE;
         end
         S_CODE: begin
            if (code_valid) begin
               // Saturation: a code arriving at full count is consumed as an error.
               if (off_img || (perim_q == '1)) begin
                  state_d = S_ERR;
               end else begin
                  cur_x_d = nx[5:0];
                  cur_y_d = ny[5:0];
                  perim_d = perim_q + 1'b1;
                  last_d  = code_last;
                  state_d = S_RD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cur_x_q <= '0;
         cur_y_q <= '0;
         st_x_q  <= '0;
         st_y_q  <= '0;
         perim_q <= '0;
         minx_q  <= '0;
         maxx_q  <= '0;
         miny_q  <= '0;
         maxy_q  <= '0;
         last_q  <= 1'b0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_x_q <= cur_x_d;
         cur_y_q <= cur_y_d;
         st_x_q  <= st_x_d;
         st_y_q  <= st_y_d;
         perim_q <= perim_d;
         minx_q  <= minx_d;
         maxx_q  <= maxx_d;
         miny_q  <= miny_d;
         maxy_q  <= maxy_d;
         last_q  <= last_d;
         row_q   <= row_d;
      end
   end

   // Outputs decode straight from the state register so an async reset
   // drops the RAM strobes immediately.
   always_comb begin
      code_ready = (state_q == S_CODE);
      mem_rd_en  = (state_q == S_RD);
      mem_we     = (state_q == S_WR);
      mem_addr   = (mem_rd_en || mem_we) ? cur_y_q : 6'd0;
      mem_wdata  = mem_we ? (row_q | pix_mask) : '0;
      Busy       = (state_q == S_RD) || (state_q == S_LATCH) ||
                   (state_q == S_WR) || (state_q == S_CODE);
      Done       = (state_q == S_DONE);
      Error      = (state_q == S_ERR);
      Closed     = Done && (cur_x_q == st_x_q) && (cur_y_q == st_y_q);
   end

   assign Perimeter = perim_q;
   assign min_x     = minx_q;
   assign max_x     = maxx_q;
   assign min_y     = miny_q;
   assign max_y     = maxy_q;

endmodule
`default_nettype wire

// File: tb/tb_chain_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chain_decoder
//  Purpose  : Self-checking bench for chain_decoder with an image RAM model
//             and a plain-arithmetic chain reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_chain_decoder;

   logic        Clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  start_x, start_y;
   logic        code_valid;
   logic        code_ready;
   logic [2:0]  code;
   logic        code_last;
   logic [5:0]  mem_addr;
   logic        mem_rd_en;
   logic [63:0] mem_rdata;
   logic        mem_we;
   logic [63:0] mem_wdata;
   logic [7:0]  Perimeter;
   logic [5:0]  min_x, max_x, min_y, max_y;
   logic        Closed, Busy, Done, Error;

   always #5 Clk = ~Clk;

   chain_decoder #(.IMG_W(64), .PERIM_W(8)) dut (
      .Clk(Clk), .reset(reset), .start(start), .start_x(start_x), .start_y(start_y),
      .code_valid(code_valid), .code_ready(code_ready), .code(code), .code_last(code_last),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .Perimeter(Perimeter),
      .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
      .Closed(Closed), .Busy(Busy), .Done(Done), .Error(Error)
   );

   // Image RAM: one-cycle read latency, pre-filled with random content.
   logic [63:0] ram [64];
   logic        fill_req;
   always @(posedge Clk) begin
      if (fill_req) begin
         for (int i = 0; i < 64; i++) ram[i] <= {$urandom, $urandom};
      end else begin
         if (mem_we)    ram[mem_addr] <= mem_wdata;
         if (mem_rd_en) mem_rdata <= ram[mem_addr];
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int          codes [300];
   logic [63:0] exp_img [64];
   int          e_per, e_minx, e_maxx, e_miny, e_maxy;
   bit          e_done, e_err, e_closed;
   int          DX [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
   int          DY [8] = '{0, -1, -1, -1, 0, 1, 1, 1};

   task automatic plot(input int x, input int y);
      exp_img[y][63-x] = 1'b1;
      if (x < e_minx) e_minx = x;
      if (x > e_maxx) e_maxx = x;
      if (y < e_miny) e_miny = y;
      if (y > e_maxy) e_maxy = y;
   endtask

   // Walks the first 'lim' codes of a chain of length n.
   task automatic model(input int sx, input int sy, input int n, input int lim);
      int cx = sx, cy = sy, nx, ny;
      e_per = 0; e_done = 0; e_err = 0;
      e_minx = sx; e_maxx = sx; e_miny = sy; e_maxy = sy;
      plot(cx, cy);
      for (int i = 0; i < lim; i++) begin
         nx = cx + DX[codes[i]];
         ny = cy + DY[codes[i]];
         if (nx < 0 || nx > 63 || ny < 0 || ny > 63 || e_per == 255) begin
            e_err = 1;
            break;
         end
         cx = nx; cy = ny; e_per++;
         plot(cx, cy);
         if (i == n - 1) begin
            e_done = 1;
            break;
         end
      end
      e_closed = e_done && cx == sx && cy == sy;
   endtask

   task automatic check_zero_outputs();
      chk("rst_busy",  64'(Busy), 0);
      chk("rst_done",  64'(Done), 0);
      chk("rst_err",   64'(Error), 0);
      chk("rst_closed",64'(Closed), 0);
      chk("rst_ready", 64'(code_ready), 0);
      chk("rst_rd",    64'(mem_rd_en), 0);
      chk("rst_we",    64'(mem_we), 0);
      chk("rst_addr",  64'(mem_addr), 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_perim", 64'(Perimeter), 0);
      chk("rst_bbox",  {40'd0, min_x, max_x, min_y, max_y}, 0);
   endtask

   task automatic run_chain(input int sx, input int sy, input int n, input int vprob,
                            input bit poke, input int rst_after);
      int idx = 0;
      bit fire = 0;
      bit ok = 0;
      @(negedge Clk);
      for (int r = 0; r < 64; r++) exp_img[r] = ram[r];
      model(sx, sy, n, (rst_after != 0) ? rst_after - 1 : n);
      start = 1; start_x = 6'(sx); start_y = 6'(sy);
      @(negedge Clk);
      for (int cyc = 0; cyc < 5000; cyc++) begin
         if (cyc > 0) @(negedge Clk);
         start = 0;
         if (fire) begin
            idx++;
            fire = 0;
            if (rst_after != 0 && idx == rst_after) begin
               code_valid = 0;
               reset = 0;
               #1 check_zero_outputs();
               @(negedge Clk);
               reset = 1;
               ok = 1;
               break;
            end
         end
         if (Done || Error) begin
            ok = 1;
            break;
         end
         code_valid = (idx < n) && ($urandom_range(99) < vprob);
         code       = 3'(codes[idx]);
         code_last  = (idx == n - 1);
         fire       = code_valid && code_ready;
         if (poke && Busy && $urandom_range(3) == 0) begin
            start = 1; start_x = 6'($urandom); start_y = 6'($urandom);
         end
      end
      code_valid = 0;
      start = 0;
      if (!ok) chk("timeout", 0, 1);
      if (rst_after == 0) begin
         chk("done",   64'(Done), 64'(e_done));
         chk("error",  64'(Error), 64'(e_err));
         chk("closed", 64'(Closed), 64'(e_closed));
         chk("busy",   64'(Busy), 0);
         chk("perim",  64'(Perimeter), 64'(e_per));
         chk("bbox", {40'd0, min_x, max_x, min_y, max_y},
             {40'd0, 6'(e_minx), 6'(e_maxx), 6'(e_miny), 6'(e_maxy)});
      end
      for (int r = 0; r < 64; r++) chk($sformatf("row%0d", r), ram[r], exp_img[r]);
   endtask

   initial begin
      reset = 0; start = 0; start_x = 0; start_y = 0;
      code_valid = 0; code = 0; code_last = 0; fill_req = 1;
      repeat (2) @(negedge Clk);
      fill_req = 0;
      check_zero_outputs();
      @(negedge Clk);
      reset = 1;

      // square loop, closed
      codes[0] = 0; codes[1] = 6; codes[2] = 4; codes[3] = 2;
      run_chain(10, 10, 4, 100, 0, 0);
      // right edge exit, then top exit from the corner
      codes[0] = 0;
      run_chain(63, 0, 1, 100, 0, 0);
      codes[0] = 2;
      run_chain(0, 0, 1, 100, 0, 0);
      // diagonal open chain
      codes[0] = 7; codes[1] = 7; codes[2] = 1;
      run_chain(5, 5, 3, 100, 0, 0);
      // perimeter saturation
      for (int i = 0; i < 256; i++) codes[i] = (i % 2 == 0) ? 0 : 4;
      run_chain(20, 20, 256, 100, 0, 0);
      // random chains, throttled valid, stray start pulses while busy
      for (int t = 0; t < 8; t++) begin
         int n = $urandom_range(20, 1);
         for (int i = 0; i < n; i++) codes[i] = $urandom_range(7);
         run_chain($urandom_range(63), $urandom_range(63), n, 50, 1, 0);
      end
      // async reset in RD of the 3rd code, then a clean decode
      codes[0] = 0; codes[1] = 0; codes[2] = 0; codes[3] = 6; codes[4] = 6;
      run_chain(30, 30, 5, 100, 0, 3);
      codes[0] = 6; codes[1] = 0; codes[2] = 2; codes[3] = 4;
      run_chain(40, 12, 4, 70, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
